// File: rtl/ifu_prefetch_if.sv
// Instruction bus between the prefetch unit (master) and the memory agent (slave).
// Request/grant issue phase plus an in-order response phase.
interface ifu_prefetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: owns the fetch PC, buffers returned words in a small FIFO, and flushes on jump.
// Optional IFU_BYPASS_EN: forwards a live response straight to the outputs when the FIFO is empty.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jump_flag_i,
  input  logic [31:0]          jump_addr_i,
  input  logic [2:0]           hold_flag_i,
  ifu_prefetch_if.master       ibus,
  output logic [31:0]          inst_o,
  output logic [31:0]          inst_addr_o,
  output logic                 inst_valid_o
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0001;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_addr [DEPTH];

  logic          req;
  logic          grant;
  logic          fifo_empty;
  logic          bypass;
  logic          pop;
  logic          fifo_pop;
  logic          live_rsp;
  logic          push;
  logic [CW:0]   credit_used;

  // Slots already promised: buffered words plus live (non-discarded) in-flight requests.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, drop_cnt};

  assign req       = !rst && !jump_flag_i && (outstanding < DEPTH_C)
                     && (credit_used < {1'b0, DEPTH_C});
  assign ibus.req  = req;
  assign ibus.addr = fetch_pc;
  assign grant     = req && ibus.gnt;

  assign fifo_empty = (fifo_count == '0);

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = NOP;
    inst_addr_o  = '0;
    bypass       = 1'b0;
    if (!fifo_empty) begin
      inst_valid_o = 1'b1;
      inst_o       = mem_inst[rd_ptr];
      inst_addr_o  = mem_addr[rd_ptr];
    end
`ifdef IFU_BYPASS_EN
    else if (!rst && drop_cnt == '0 && ibus.rvalid) begin
      bypass       = 1'b1;
      inst_valid_o = 1'b1;
      inst_o       = ibus.rdata;
      inst_addr_o  = rsp_pc;
    end
`endif
  end

  // Any hold keeps the head: IF/ID turns the held slot into a bubble.
  assign pop      = inst_valid_o && (hold_flag_i == 3'd0) && !jump_flag_i;
  assign fifo_pop = pop && !fifo_empty;
  assign live_rsp = ibus.rvalid && (drop_cnt == '0);
  assign push     = live_rsp && !jump_flag_i && !(bypass && pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (jump_flag_i) begin
      // Every response still in flight, except one landing now, belongs to the old stream.
      fetch_pc    <= jump_addr_i;
      rsp_pc      <= jump_addr_i;
      outstanding <= outstanding - CW'(ibus.rvalid);
      drop_cnt    <= outstanding - CW'(ibus.rvalid);
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(grant) - CW'(ibus.rvalid);
      if (ibus.rvalid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        else                rsp_pc   <= rsp_pc + 32'd4;
      end
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= ibus.rdata;
      mem_addr[wr_ptr] <= rsp_pc;
    end
  end

  a_fifo_bound : assert property (@(posedge clk) disable iff (rst) fifo_count <= DEPTH_C);
  a_drop_bound : assert property (@(posedge clk) disable iff (rst)
                                  (drop_cnt <= outstanding) && (outstanding <= DEPTH_C));
  a_no_overrun : assert property (@(posedge clk) disable iff (rst) push |-> (fifo_count < DEPTH_C));
  a_rsp_owed   : assert property (@(posedge clk) disable iff (rst) ibus.rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch: a bus agent with random grant/latency and a stream-level reference model.
module tb_ifu_prefetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic [2:0]  hold_flag_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  ifu_prefetch_if ibus ();

  ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .ibus         (ibus),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } rsp_t;

  rsp_t        rq[$];
  int          cyc, last_due, buffered, n_chk, n_pass;
  int          k_min, k_max;
  logic [31:0] exp_req_addr, exp_pop_addr, prev_addr;
  bit          prev_pending;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic int live_count();
    int n = 0;
    foreach (rq[i]) if (rq[i].live) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic model_reset();
    rq.delete();
    last_due     = 0;
    buffered     = 0;
    exp_req_addr = RESET_PC;
    exp_pop_addr = RESET_PC;
    prev_pending = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      rst = 1'b1; ibus.gnt = 1'b0; ibus.rvalid = 1'b0; ibus.rdata = '0;
      jump_flag_i = 1'b0; hold_flag_i = '0;
      #1;
      chk("rst_req", ibus.req, 0);
      if (i > 0) begin
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_addr", inst_addr_o, 0);
      end
    end
    model_reset();
  endtask

  // One bus cycle: drive, sample, compare against the model, then advance the model past the edge.
  task automatic step(input bit gnt_en, input logic [2:0] hold, input bit jmp, input logic [31:0] jaddr);
    int live_n, due;
    bit exp_req, exp_valid, head_live, pop;
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    ibus.rvalid = 1'b0;
    head_live   = 1'b0;
    if (rq.size() > 0) begin
      if (rq[0].due <= cyc) begin
        ibus.rvalid = 1'b1;
        head_live   = rq[0].live;
      end
    end
    ibus.rdata  = ibus.rvalid ? mem_word(rq[0].addr) : $urandom();
    ibus.gnt    = gnt_en;
    hold_flag_i = hold;
    jump_flag_i = jmp;
    jump_addr_i = jaddr;
    #1;
    live_n    = live_count();
    exp_req   = !jmp && (rq.size() < DEPTH) && ((buffered + live_n) < DEPTH);
    exp_valid = (buffered > 0);
`ifdef IFU_BYPASS_EN
    if (buffered == 0 && head_live) exp_valid = 1'b1;
`endif
    chk("ibus_req", ibus.req, exp_req);
    if (prev_pending && !jmp) chk("addr_hold", ibus.addr, prev_addr);
    if (exp_req) chk("ibus_addr", ibus.addr, exp_req_addr);
    chk("inst_valid", inst_valid_o, exp_valid);
    if (exp_valid) begin
      chk("inst_addr", inst_addr_o, exp_pop_addr);
      chk("inst", inst_o, mem_word(exp_pop_addr));
    end else begin
      chk("nop_inst", inst_o, NOP);
      chk("nop_addr", inst_addr_o, 0);
    end
    pop = exp_valid && (hold == 3'd0) && !jmp;
    if (ibus.rvalid) begin
      if (head_live && !jmp) buffered++;
      void'(rq.pop_front());
    end
    if (pop) begin
      buffered--;
      exp_pop_addr += 32'd4;
    end
    if (ibus.req && gnt_en) begin
      due = cyc + $urandom_range(k_max, k_min);
      if (due <= last_due) due = last_due + 1;
      rq.push_back('{ibus.addr, due, 1'b1});
      last_due = due;
      exp_req_addr += 32'd4;
    end
    prev_pending = ibus.req && !gnt_en;
    prev_addr    = ibus.addr;
    if (jmp) begin
      foreach (rq[i]) rq[i].live = 1'b0;
      buffered     = 0;
      exp_req_addr = jaddr;
      exp_pop_addr = jaddr;
    end
  endtask

  initial begin
    int first, found, exp_first;
    logic [31:0] ja;
    n_chk = 0; n_pass = 0; cyc = 0;
    k_min = 1; k_max = 1;
    ibus.gnt = 1'b0; ibus.rvalid = 1'b0; ibus.rdata = '0;
    model_reset();

    // Streaming from reset with an immediate grant and 1-cycle response.
    do_reset(3);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 3'd0, 1'b0, '0);
      if (inst_valid_o && first == 0) first = i;
    end
`ifdef IFU_BYPASS_EN
    exp_first = 2;
`else
    exp_first = 3;
`endif
    chk("first_valid_cycle", first, exp_first);

    // ID hold for five cycles mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, 3'd3, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 3'd0, 1'b0, '0);

    // Jump with two responses in flight on a slow bus.
    do_reset(2);
    k_min = 3; k_max = 3;
    for (int i = 0; i < 20 && live_count() < 2; i++) step(1'b1, 3'd0, 1'b0, '0);
    chk("two_in_flight", live_count(), 2);
    step(1'b1, 3'd0, 1'b1, 32'h100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 3'd0, 1'b0, '0);
      if (inst_valid_o) begin
        found = 1;
        chk("jump_target", inst_addr_o, 32'h100);
      end
    end
    if (!found) chk("jump_timeout", 0, 1);

    // Jump landing on a response cycle with a non-empty FIFO.
    k_min = 1; k_max = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (buffered > 0 && rq.size() > 0 && rq[0].live && rq[0].due <= cyc + 1) found = 1;
      else step(1'b1, (i % 2) ? 3'd3 : 3'd0, 1'b0, '0);
    end
    if (!found) chk("rsp_jump_setup", 0, 1);
    step(1'b1, 3'd0, 1'b1, 32'h200);
    step(1'b1, 3'd0, 1'b0, '0);
    chk("post_jump_empty", inst_valid_o, 0);
    for (int i = 0; i < 6; i++) step(1'b1, 3'd0, 1'b0, '0);

    // Grant withheld for four cycles after reset.
    do_reset(2);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 3'd0, 1'b0, '0);

    // Address wrap, then reset with traffic in flight.
    step(1'b1, 3'd0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) step(1'b1, 3'd0, 1'b0, '0);
    k_min = 2; k_max = 4;
    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 1'b0, '0);
    do_reset(2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      k_min = 1; k_max = $urandom_range(4, 1);
      if ($urandom_range(999, 0) < 3) do_reset(2);
      else begin
        ja = {$urandom(), 2'b00};
        if ($urandom_range(3, 0) == 0) ja = 32'hFFFF_FFF0 | {28'h0, ja[3:2], 2'b00};
        step($urandom_range(9, 0) < 7,
             ($urandom_range(9, 0) < 6) ? 3'd0 : 3'($urandom_range(3, 1)),
             $urandom_range(99, 0) < 4, ja);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
